mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake, a one-entry skid buffer, flush, and write-back data selection.
- Sits between the data-memory stage and the register-file write port.
- Replaces the free-running MEM/WB register.
- Adds back-pressure, bubble tracking, flush, and a register-0 write guard.

Parameters:
- DATA_W, 32, width of memory read data, ALU result and write-back data.
- REG_ADDR_W, 5, width of the destination register index.
- ZERO_REG_GUARD, 1, when 1 a write to register index 0 is forced to reg_write=0.
- SKID_EN, 1, when 1 a skid entry registers in_ready; when 0 in_ready is combinational and there is no skid entry.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and the current input.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_read_data  in  DATA_W  data-memory read result.
- in_alu_result  in  DATA_W  ALU result or address.
- in_write_reg  in  REG_ADDR_W  destination register.
- in_reg_write  in  1  register-write enable.
- in_mem_to_reg  in  1  1 selects in_read_data, 0 selects in_alu_result.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts; tie to 1 for the register file.
- out_write_data  out  DATA_W  selected write-back value.
- out_write_reg  out  REG_ADDR_W  destination register.
- out_reg_write  out  1  gated write enable.
- out_fwd_valid  out  1  out_valid & out_reg_write, for the forwarding unit.

Behaviour:
- Clock and reset:
  - Single clock domain. All state updates only on the rising edge of clk.
  - Reset is synchronous and active-high.
- Reset:
  - After the first clk edge with reset=1: out_valid=0, skid empty, out_write_data=0, out_write_reg=0, out_reg_write=0, out_fwd_valid=0.
  - in_ready=1 after that edge when SKID_EN=1.
  - Reset has priority over flush and over any handshake.
- Entry packing:
  - An entry holds {write_data, write_reg, reg_write}.
  - write_data = in_mem_to_reg ? in_read_data : in_alu_result. The selection is made at capture and only the selected value is stored.
  - reg_write = in_reg_write & ~(ZERO_REG_GUARD & (in_write_reg == 0)).
- Handshake:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on the outputs after edge N.
- SKID_EN=1:
  - in_ready = ~skid_full, driven directly from a register.
  - Main empty, or main draining this cycle: the input loads main.
  - Main full and not draining, with an input transfer: the input loads the skid entry.
  - Main drains while the skid is full: skid moves to main and the skid empties.
  - Skid full: in_ready=0, so a third entry is never accepted.
- SKID_EN=0:
  - in_ready = out_ready | ~out_valid.
  - Only the main entry exists.
- Out-of-range states: while out_valid=0 the output data fields hold their last value, and verification must not check them. out_fwd_valid must be 0.
- Flush:
  - At the edge where flush=1: main and skid are both cleared (out_valid=0, skid empty).
  - An input transfer in the same cycle is dropped.
  - An output transfer in the same cycle still counts as consumed downstream.
  - in_ready=1 on the following cycle.
- Simultaneous events:
  - Input and output transfer in the same cycle with the skid empty: main is replaced, out_valid stays 1, and there is no bubble.
  - Throughput is one entry per cycle while out_ready=1.
- Ordering: entries leave in acceptance order, never reordered or duplicated.
- Combinational paths: out_* depend only on registers. in_ready depends only on registers when SKID_EN=1.

Decomposition:
- Shared package pipe_pkg holds:
  - the DATA_W and REG_ADDR_W defaults;
  - REG_ZERO = 0;
  - the struct/typedef wb_entry_t {write_data, write_reg, reg_write}, shared with the register file and the forwarding unit.
- One natural sub-module: skid_buffer.
  - Generic valid/ready two-entry elastic buffer with flush, parametrised on entry width.
  - mem_wb_stage instantiates it and adds the write-back select and the zero-register guard around it.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then three entries each with out_ready=1:
  - entry A: read_data=0xDEADBEEF, mem_to_reg=1, write_reg=8, reg_write=1;
  - entry B: alu=0x00000010, mem_to_reg=0, write_reg=9;
  - entry C: alu=0x7, write_reg=10.
  - Required: one cycle after each acceptance the outputs show (0xDEADBEEF,8,1), then (0x10,9,1), then (0x7,10,1), back-to-back with out_valid held at 1.
- Zero-register guard: in_write_reg=0, in_reg_write=1, alu=0x55.
  - Required: out_reg_write=0 and out_fwd_valid=0 while out_write_data=0x55.
  - With ZERO_REG_GUARD=0 the same stimulus gives out_reg_write=1.
- Back-pressure: hold out_ready=0, offer entries 0x1 then 0x2.
  - Required: in_ready drops to 0 after the second acceptance, and a third entry 0x3 is held upstream.
  - Raise out_ready: outputs 0x1, 0x2, 0x3 in order, with no loss or duplication.
- Flush mid-stall: main=0xA, skid=0xB, out_ready=0; assert flush together with in_valid=1 carrying 0xC.
  - Required: out_valid=0 next cycle, in_ready=1, and 0xA, 0xB and 0xC never appear.
- Reset mid-operation: with both entries full, assert reset together with flush=0 and in_valid=1.
  - Required: all outputs zero and out_valid=0 after that edge, with the input not captured.
- SKID_EN=0 build: toggle out_ready on alternate cycles with in_valid=1.
  - Required: in_ready equals out_ready | ~out_valid combinationally in the same cycle, and every accepted entry emerges exactly once.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and write-back entry type
package pipe_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_REG_ADDR_W = 5;
    localparam int REG_ZERO        = 0;

    // Write-back entry as seen by the register file and forwarding unit.
    typedef struct packed {
        logic [PIPE_DATA_W-1:0]     write_data;
        logic [PIPE_REG_ADDR_W-1:0] write_reg;
        logic                       reg_write;
    } wb_entry_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - valid/ready elastic buffer (main + optional skid entry) with flush
module skid_buffer #(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid, skid_valid, ready_q;
    logic [W-1:0] main_data, skid_data;
    logic         main_valid_n, skid_valid_n;
    logic [W-1:0] main_data_n, skid_data_n;
    logic         in_xfer, out_xfer;

    assign in_ready  = SKID_EN ? ready_q : (out_ready | ~main_valid);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_data_n  = main_data;
        skid_data_n  = skid_data;
        if (out_xfer)
            main_valid_n = 1'b0;
        // A full skid blocks the input, so only the refill path can run.
        if (skid_valid && out_xfer) begin
            main_valid_n = 1'b1;
            main_data_n  = skid_data;
            skid_valid_n = 1'b0;
        end else if (in_xfer) begin
            if (!main_valid || out_xfer) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end else if (SKID_EN) begin
                skid_valid_n = 1'b1;
                skid_data_n  = in_data;
            end
        end
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
            ready_q    <= ~skid_valid_n;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: write-back select, zero-register guard, elastic handshake
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W,
    parameter int REG_ADDR_W     = PIPE_REG_ADDR_W,
    parameter bit ZERO_REG_GUARD = 1'b1,
    parameter bit SKID_EN        = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_read_data,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_write_data,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic                  out_reg_write,
    output logic                  out_fwd_valid
);

    localparam int ENTRY_W = DATA_W + REG_ADDR_W + 1;

    logic [DATA_W-1:0]  sel_data;
    logic               sel_reg_write;
    logic [ENTRY_W-1:0] in_entry, out_entry;

    // Only the selected value is stored, so the entry stays one data word wide.
    assign sel_data      = in_mem_to_reg ? in_read_data : in_alu_result;
    assign sel_reg_write = in_reg_write &
                           ~(ZERO_REG_GUARD && (in_write_reg == REG_ADDR_W'(REG_ZERO)));
    assign in_entry      = {sel_data, in_write_reg, sel_reg_write};

    skid_buffer #(
        .W       (ENTRY_W),
        .SKID_EN (SKID_EN)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign {out_write_data, out_write_reg, out_reg_write} = out_entry;
    assign out_fwd_valid = out_valid & out_reg_write;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a queue reference model
module tb_mem_wb_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
    logic [2:0]  iv, ordy, ir, ov, orw, ofv;
    logic [31:0] owd [3];
    logic [4:0]  owr [3];

    // 0: default build, 1: no zero-register guard, 2: no skid entry
    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(1'b1), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_read_data(rd), .in_alu_result(alu), .in_write_reg(wr), .in_reg_write(rw),
        .in_mem_to_reg(m2r), .out_valid(ov[0]), .out_ready(ordy[0]), .out_write_data(owd[0]),
        .out_write_reg(owr[0]), .out_reg_write(orw[0]), .out_fwd_valid(ofv[0]));

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(1'b0), .SKID_EN(1'b1)) dut_ng (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_read_data(rd), .in_alu_result(alu), .in_write_reg(wr), .in_reg_write(rw),
        .in_mem_to_reg(m2r), .out_valid(ov[1]), .out_ready(ordy[1]), .out_write_data(owd[1]),
        .out_write_reg(owr[1]), .out_reg_write(orw[1]), .out_fwd_valid(ofv[1]));

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_GUARD(1'b1), .SKID_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_read_data(rd), .in_alu_result(alu), .in_write_reg(wr), .in_reg_write(rw),
        .in_mem_to_reg(m2r), .out_valid(ov[2]), .out_ready(ordy[2]), .out_write_data(owd[2]),
        .out_write_reg(owr[2]), .out_reg_write(orw[2]), .out_fwd_valid(ofv[2]));

    int        sel = 0;
    int        nvec = 0;
    int        nerr = 0;
    bit        known = 1'b0;
    logic      in_v, o_rdy;
    wb_entry_t q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(bit v, logic [31:0] a, logic [4:0] r, bit w);
        in_v = v; alu = a; wr = r; rw = w; m2r = 1'b0; rd = ~a;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic tick(string tag);
        bit guard, skid, exp_ir, ixf, oxf;
        wb_entry_t e;
        guard = (sel != 1);
        skid  = (sel != 2);
        iv = '0; ordy = '1;
        iv[sel] = in_v; ordy[sel] = o_rdy;
        #1;
        exp_ir = skid ? (q.size() < 2) : (o_rdy || q.size() == 0);
        if (known) chk({tag, ".in_ready"}, 32'(ir[sel]), 32'(exp_ir));
        e.write_data = m2r ? rd : alu;
        e.write_reg  = wr;
        e.reg_write  = rw && !(guard && wr == 5'd0);
        @(posedge clk);
        if (reset) begin
            q.delete();
            known = 1'b1;
        end else if (known) begin
            oxf = (q.size() > 0) && o_rdy;
            ixf = in_v && exp_ir;
            if (flush) q.delete();
            else begin
                if (oxf) void'(q.pop_front());
                if (ixf) q.push_back(e);
            end
        end
        @(negedge clk);
        if (known) begin
            chk({tag, ".out_valid"}, 32'(ov[sel]), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk({tag, ".write_data"}, owd[sel], q[0].write_data);
                chk({tag, ".write_reg"}, 32'(owr[sel]), 32'(q[0].write_reg));
                chk({tag, ".reg_write"}, 32'(orw[sel]), 32'(q[0].reg_write));
                chk({tag, ".fwd_valid"}, 32'(ofv[sel]), 32'(q[0].reg_write));
            end else begin
                chk({tag, ".fwd_idle"}, 32'(ofv[sel]), 32'd0);
            end
            if (reset) begin
                chk({tag, ".rst_data"}, owd[sel], 32'd0);
                chk({tag, ".rst_reg"}, 32'(owr[sel]), 32'd0);
                chk({tag, ".rst_rw"}, 32'(orw[sel]), 32'd0);
            end
        end
    endtask

    task automatic rand_run(int n);
        for (int i = 0; i < n; i++) begin
            in_v  = 1'($urandom_range(0, 1));
            o_rdy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rd    = $urandom;
            alu   = $urandom;
            wr    = 5'($urandom_range(0, 7));
            rw    = 1'($urandom_range(0, 1));
            m2r   = 1'($urandom_range(0, 1));
            tick("rand");
        end
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_v = 1'b0; o_rdy = 1'b1;
        rd = '0; alu = '0; wr = '0; rw = 1'b0; m2r = 1'b0;
        iv = '0; ordy = '1;

        sel = 0;
        tick("reset0"); tick("reset1");
        reset = 1'b0;

        // Back-to-back stream A, B, C
        in_v = 1'b1; rd = 32'hDEADBEEF; alu = 32'h0; wr = 5'd8; rw = 1'b1; m2r = 1'b1;
        tick("strA");
        put(1'b1, 32'h10, 5'd9, 1'b1);  tick("strB");
        put(1'b1, 32'h7, 5'd10, 1'b1);  tick("strC");
        put(1'b0, 32'h0, 5'd0, 1'b0);   tick("strEnd");

        put(1'b1, 32'h55, 5'd0, 1'b1);  tick("zguard");
        put(1'b0, 32'h0, 5'd1, 1'b0);   tick("zguardEnd");

        // Back-pressure: third entry is held upstream until space frees
        o_rdy = 1'b0;
        put(1'b1, 32'h1, 5'd1, 1'b1);   tick("bp1");
        put(1'b1, 32'h2, 5'd2, 1'b1);   tick("bp2");
        put(1'b1, 32'h3, 5'd3, 1'b1);   tick("bp3a"); tick("bp3b");
        o_rdy = 1'b1;                   tick("bpDrain1"); tick("bpDrain2");
        in_v = 1'b0;                    tick("bpDrain3"); tick("bpDrain4");

        // Flush with both entries full and an offered input
        o_rdy = 1'b0;
        put(1'b1, 32'hA, 5'd4, 1'b1);   tick("flA");
        put(1'b1, 32'hB, 5'd5, 1'b1);   tick("flB");
        put(1'b1, 32'hC, 5'd6, 1'b1); flush = 1'b1; tick("flush");
        flush = 1'b0; in_v = 1'b0;      tick("flushAfter");
        o_rdy = 1'b1;                   tick("flushIdle");

        // Reset while both entries are full and input is offered
        o_rdy = 1'b0;
        put(1'b1, 32'h11, 5'd7, 1'b1);  tick("rmA");
        put(1'b1, 32'h22, 5'd8, 1'b1);  tick("rmB");
        put(1'b1, 32'h33, 5'd9, 1'b1); reset = 1'b1; tick("rmReset");
        reset = 1'b0; in_v = 1'b0; o_rdy = 1'b1; tick("rmAfter");

        rand_run(200);

        // No-guard build
        sel = 1; reset = 1'b1; in_v = 1'b0; o_rdy = 1'b1;
        tick("ngReset");
        reset = 1'b0;
        put(1'b1, 32'h55, 5'd0, 1'b1);  tick("ngZero");
        in_v = 1'b0;                    tick("ngEnd");
        rand_run(60);

        // No-skid build: alternate out_ready with input always offered
        sel = 2; reset = 1'b1; in_v = 1'b0; o_rdy = 1'b1;
        tick("nsReset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put(1'b1, 32'(i + 100), 5'(i % 8), 1'b1);
            o_rdy = i[0];
            tick("nsAlt");
        end
        in_v = 1'b0; o_rdy = 1'b1; tick("nsDrain"); tick("nsDrain2");
        rand_run(120);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
